// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter unit with prioritised redirect, stall and return-address stack
//
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect targets trap to TRAP_VEC)
//
// Ports:
//   clk_i            in   1      clock, rising edge
//   rst_i            in   1      synchronous reset, active-low
//   start_i          in   1      1 = running, 0 = freeze PC and RAS
//   pc_write_i       in   1      0 = stall (hold PC), 1 = advance
//   branch_i         in   1      taken branch redirect
//   branch_target_i  in   WIDTH  branch target
//   jump_i           in   1      jump redirect
//   jump_target_i    in   WIDTH  jump target, also fallback for ret on empty RAS
//   call_i           in   1      qualifies jump_i as a call (push ret_addr_i)
//   ret_addr_i       in   WIDTH  return address pushed on call
//   ret_i            in   1      return: pop RAS and redirect
//   pc_o             out  WIDTH  current PC
//   pc_valid_o       out  1      pc_o was produced while running
//   ras_empty_o      out  1      RAS count == 0
//   ras_full_o       out  1      RAS count == RAS_DEPTH
//   err_o            out  1      pulse: ret on empty RAS, or call and ret together
//   misalign_o       out  1      pulse: misaligned redirect trapped
module pc_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0,
  parameter int                 INC       = 4,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]   TRAP_VEC  = 'h80
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] ret_addr_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             err_o,
  output logic             misalign_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             push, pop, redirect, mis_sel;
  logic [WIDTH-1:0] tgt;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty, ras_full;

  // ptr_q addresses the next free slot; the most recent entry sits one below it.
  assign top_idx   = ptr_q - PTR_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

`ifdef PC_ALIGN_CHECK_EN
  assign mis_sel = redirect && (tgt[1:0] != 2'b00);
`else
  assign mis_sel = 1'b0;
`endif

  always_comb begin
    pc_d     = pc_q;
    valid_d  = start_i;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    err_d    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    redirect = 1'b0;
    tgt      = jump_target_i;

    if (start_i) begin
      if (ret_i) begin
        redirect = 1'b1;
        // A simultaneous call is flagged and its push dropped; ret still wins.
        err_d    = ras_empty | call_i;
        if (!ras_empty) begin
          tgt = ras_q[top_idx];
          pop = 1'b1;
        end else begin
          tgt = jump_target_i;
        end
      end else if (jump_i) begin
        redirect = 1'b1;
        tgt      = jump_target_i;
        push     = call_i;
      end else if (branch_i) begin
        redirect = 1'b1;
        tgt      = branch_target_i;
      end

      // Redirects are taken even while the hazard unit stalls.
      if (redirect) begin
        pc_d = mis_sel ? TRAP_VEC : tgt;
      end else if (pc_write_i) begin
        pc_d = pc_q + WIDTH'(INC);
      end
    end

    if (push) begin
      // On a full stack the write lands on the oldest entry; count saturates.
      ptr_d = ptr_q + PTR_W'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end

    mis_d = mis_sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Stack contents need no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) begin
      ras_q[ptr_q] <= ret_addr_i;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;
  assign err_o       = err_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, pc_write_i, branch_i, jump_i, call_i, ret_i;
  logic [31:0] branch_target_i, jump_target_i, ret_addr_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ras_empty_o, ras_full_o, err_o, misalign_o;

  pc_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_write_i(pc_write_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .call_i(call_i), .ret_addr_i(ret_addr_i), .ret_i(ret_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .ras_empty_o(ras_empty_o),
    .ras_full_o(ras_full_o), .err_o(err_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        valid, empty, full, err, mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  // Monitor: results of the previous rising edge are sampled on the falling edge.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_o",        e.id, pc_o,               e.pc);
      chk("pc_valid_o",  e.id, {31'b0, pc_valid_o}, {31'b0, e.valid});
      chk("ras_empty_o", e.id, {31'b0, ras_empty_o}, {31'b0, e.empty});
      chk("ras_full_o",  e.id, {31'b0, ras_full_o}, {31'b0, e.full});
      chk("err_o",       e.id, {31'b0, err_o},      {31'b0, e.err});
      chk("misalign_o",  e.id, {31'b0, misalign_o}, {31'b0, e.mis});
    end
  end

  // One cycle of stimulus plus the hand-computed outputs after the next rising edge.
  task automatic cyc(input logic rst, input logic start, input logic pcw,
                     input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt,
                     input logic call, input logic [31:0] ra, input logic ret,
                     input logic [31:0] e_pc, input logic e_valid, input logic e_empty,
                     input logic e_full, input logic e_err, input logic e_mis);
    exp_t e;
    @(negedge clk_i);
    #1;
    rst_i = rst; start_i = start; pc_write_i = pcw;
    branch_i = br; branch_target_i = bt;
    jump_i = j; jump_target_i = jt;
    call_i = call; ret_addr_i = ra; ret_i = ret;
    step_id++;
    e.id = step_id; e.pc = e_pc; e.valid = e_valid; e.empty = e_empty;
    e.full = e_full; e.err = e_err; e.mis = e_mis;
    sb.push_back(e);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_write_i = 1'b0;
    branch_i = 1'b0; branch_target_i = '0; jump_i = 1'b0; jump_target_i = '0;
    call_i = 1'b0; ret_addr_i = '0; ret_i = 1'b0;

    //   rst st pcw br bt           j  jt          call ra      ret   pc           v  emp full err mis
    // reset, then sequential fetch
    cyc(0, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h0,       0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h0,       0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h4,       1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h8,       1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'hC,       1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h10,      1, 1, 0, 0, 0);
    // stall, then branch overriding stall
    cyc(1, 1, 0, 0, 0,           0, 0,          0, 0,       0,    32'h10,      1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0,           0, 0,          0, 0,       0,    32'h10,      1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0,           0, 0,          0, 0,       0,    32'h10,      1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h40,      0, 0,          0, 0,       0,    32'h40,      1, 1, 0, 0, 0);
    // call / ret pair
    cyc(1, 1, 1, 0, 0,           1, 32'h100,    1, 32'h14,  0,    32'h100,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h104,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       1,    32'h14,      1, 1, 0, 0, 0);
    // five calls into a four-deep stack, then five returns
    cyc(1, 1, 1, 0, 0,           1, 32'h200,    1, 32'h4,   0,    32'h200,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           1, 32'h200,    1, 32'h8,   0,    32'h200,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           1, 32'h200,    1, 32'hC,   0,    32'h200,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           1, 32'h200,    1, 32'h10,  0,    32'h200,     1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0,           1, 32'h200,    1, 32'h14,  0,    32'h200,     1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h300,    0, 0,       1,    32'h14,      1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h300,    0, 0,       1,    32'h10,      1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h300,    0, 0,       1,    32'hC,       1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h300,    0, 0,       1,    32'h8,       1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h300,    0, 0,       1,    32'h300,     1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h304,     1, 1, 0, 0, 0);
    // call and ret together: ret wins, push dropped, error flagged
    cyc(1, 1, 1, 0, 0,           1, 32'h500,    1, 32'h50,  0,    32'h500,     1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           1, 32'h600,    1, 32'h60,  1,    32'h50,      1, 1, 0, 1, 0);
    // call without jump is ignored
    cyc(1, 1, 1, 0, 0,           0, 0,          1, 32'h70,  0,    32'h54,      1, 1, 0, 0, 0);
    // jump beats branch; jump beats stall
    cyc(1, 1, 1, 1, 32'hB00,     1, 32'hA00,    0, 0,       0,    32'hA00,     1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0,           1, 32'hC00,    0, 0,       0,    32'hC00,     1, 1, 0, 0, 0);
    // increment wraps modulo 2^32
    cyc(1, 1, 1, 1, 32'hFFFFFFFC, 0, 0,         0, 0,       0,    32'hFFFFFFFC, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h0,       1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h4,       1, 1, 0, 0, 0);
    // start_i=0 freezes PC and RAS
    cyc(1, 0, 1, 0, 0,           1, 32'h700,    1, 32'h77,  0,    32'h4,       0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h8,       1, 1, 0, 0, 0);
    // reset in the middle of a call sequence empties the RAS
    cyc(1, 1, 1, 0, 0,           1, 32'h800,    1, 32'h88,  0,    32'h800,     1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0,           1, 32'h900,    1, 32'h99,  0,    32'h0,       0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 32'h940,    0, 0,       1,    32'h940,     1, 1, 0, 1, 0);
    // misaligned branch target
`ifdef PC_ALIGN_CHECK_EN
    cyc(1, 1, 1, 1, 32'h42,      0, 0,          0, 0,       0,    32'h80,      1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h84,      1, 1, 0, 0, 0);
`else
    cyc(1, 1, 1, 1, 32'h42,      0, 0,          0, 0,       0,    32'h42,      1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,           0, 0,          0, 0,       0,    32'h46,      1, 1, 0, 0, 0);
`endif

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk_i);
      #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
